// File: rtl/eight_bit_serial_subtractor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : eight_bit_serial_subtractor
// Purpose  : Bit-serial a - b - bin, one bit per clock LSB first, with a
//            start/busy/done handshake. Define SUB_OVF_EN to add the ovf port.
// Revision : 1.0
// ============================================================================
module eight_bit_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next;
  logic             br, br_next, d_bit;
  logic [CW-1:0]    count;
  logic             load, step, last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (count == LAST_BIT) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        // A start seen while done is high chains the next operation directly.
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Single full-subtractor cell on bit 0 of the operand shift registers.
  assign d_bit    = a_sr[0] ^ b_sr[0] ^ br;
  assign br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  assign res_next = {d_bit, res_sr[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      count  <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (load) begin
      a_sr   <= a;
      b_sr   <= b;
      res_sr <= '0;
      br     <= bin;
      count  <= '0;
      busy   <= 1'b1;
      done   <= 1'b0;
    end else if (step) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_next;
      br     <= br_next;
      count  <= count + CW'(1);
      if (last) begin
        diff <= res_next;
        bout <= br_next;
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

`ifdef SUB_OVF_EN
  // On the MSB step, br is the borrow into the MSB and br_next the borrow out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     ovf <= 1'b0;
    else if (last) ovf <= br ^ br_next;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_eight_bit_serial_subtractor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_eight_bit_serial_subtractor
// Purpose  : Directed and random checks of the serial subtractor against an
//            arithmetic reference model; builds with or without SUB_OVF_EN.
// Revision : 1.0
// ============================================================================
module tb_eight_bit_serial_subtractor;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] a, b;
  logic       bin;
  logic [7:0] diff;
  logic       bout, busy, done;
  logic       ovf_obs;

  int vectors   = 0;
  int errors    = 0;
  int done_cnt  = 0;
  int accepted  = 0;

  eight_bit_serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .diff  (diff),
    .bout  (bout),
    .busy  (busy),
    .done  (done)
`ifdef SUB_OVF_EN
    ,
    .ovf   (ovf_obs)
`endif
  );

`ifndef SUB_OVF_EN
  assign ovf_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin);
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    accepted++;
  endtask

  task automatic wait_done(output int cyc, output int busy_cyc);
    cyc = 0; busy_cyc = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_cyc++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic check_ovf(input string tag, input logic exp);
`ifdef SUB_OVF_EN
    check_val(tag, ovf_obs, exp);
`endif
  endtask

  task automatic run_directed(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                              input logic tbin, input logic [7:0] ed, input logic eb, input logic eo);
    int cyc, bc;
    start_op(ta, tb_, tbin);
    wait_done(cyc, bc);
    check_val({tag, " latency"}, cyc, 8);
    check_val({tag, " busy"}, bc, 8);
    check_val({tag, " diff"}, diff, ed);
    check_val({tag, " bout"}, bout, eb);
    check_ovf({tag, " ovf"}, eo);
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  task automatic model(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin,
                       output logic [7:0] ed, output logic eb, output logic eo);
    int u, s;
    u  = int'(ta) - int'(tb_) - int'(tbin);
    s  = int'($signed(ta)) - int'($signed(tb_)) - int'(tbin);
    ed = u[7:0];
    eb = (u < 0);
    eo = (s > 127) || (s < -128);
  endtask

  initial begin
    int cyc, bc, snap;
    logic [7:0] ra, rb, ed;
    logic rbin, eb, eo;

    reset = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset diff", diff, 0);
    check_val("reset bout", bout, 0);
    check_val("reset busy", busy, 0);
    check_val("reset done", done, 0);
    check_ovf("reset ovf", 1'b0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    run_directed("t1", 8'h5A, 8'h1F, 1'b0, 8'h3B, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_val("t1 done width", done, 0);
    run_directed("t2", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    run_directed("t3", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_directed("t4", 8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0);

    // Back-to-back: start held high while done is high.
    a = 8'h03; b = 8'h01; bin = 1'b0; start = 1'b1;
    accepted++;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end while (!done && cyc < 40);
    check_val("t4 b2b latency", cyc, 9);
    check_val("t4 b2b diff", diff, 8'h02);
    check_val("t4 b2b bout", bout, 0);

    // Start during SHIFT is ignored; outputs hold the previous result.
    start_op(8'h33, 8'h11, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    check_val("t5 busy mid", busy, 1);
    check_val("t5 diff hold", diff, 8'h02);
    a = 8'hAA; b = 8'h55; bin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc, bc);
    check_val("t5 ign latency", cyc, 3);
    check_val("t5 ign diff", diff, 8'h22);
    check_val("t5 ign bout", bout, 0);

    // Asynchronous reset mid-operation abandons it.
    start_op(8'h44, 8'h22, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    snap = done_cnt;
    reset = 1'b1;
    #1;
    check_val("t5 rst busy", busy, 0);
    check_val("t5 rst done", done, 0);
    check_val("t5 rst diff", diff, 0);
    check_val("t5 rst bout", bout, 0);
    check_ovf("t5 rst ovf", 1'b0);
    accepted--;
    @(negedge clk) reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check_val("t5 no done", done_cnt, snap);
    run_directed("t5 next", 8'hFF, 8'h0F, 1'b0, 8'hF0, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      model(ra, rb, rbin, ed, eb, eo);
      start_op(ra, rb, rbin);
      wait_done(cyc, bc);
      check_val("rnd latency", cyc, 8);
      check_val("rnd diff", diff, ed);
      check_val("rnd bout", bout, eb);
      check_ovf("rnd ovf", eo);
    end

    repeat (3) @(posedge clk);
    #1;
    check_val("done count", done_cnt, accepted);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
